// File: rtl/des_arbiter.sv
// des_arbiter: round-robin front end sharing one DES pipeline between two
// requesters, with per-requester credits, a tag FIFO and result buffers.
module des_arbiter #(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  input  logic [63:0] i_req0_data,
  input  logic [63:0] i_req0_key,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [63:0] i_req1_data,
  input  logic [63:0] i_req1_key,
  output logic        o_req1_ready,
  output logic        o_rsp0_valid,
  output logic [63:0] o_rsp0_data,
  input  logic        i_rsp0_ready,
  output logic        o_rsp1_valid,
  output logic [63:0] o_rsp1_data,
  input  logic        i_rsp1_ready,
  output logic [63:0] o_des_cleartext,
  output logic [63:0] o_des_key,
  output logic        o_des_dv,
  input  logic [63:0] i_des_ciphertext,
  input  logic        i_des_dv,
  output logic        o_busy,
  output logic        o_err
);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int TD  = LATENCY + 1;
  localparam int TW  = (TD > 1) ? $clog2(TD) : 1;
  localparam int TCW = $clog2(TD + 1);

  logic          rr;
  logic [1:0]    req_v, rsp_r;
  logic [1:0]    elig, grant, rsp_pop, b_full, buf_wr;
  logic [CW-1:0] credit [2];
  logic [AW-1:0] b_wp [2];
  logic [AW-1:0] b_rp [2];
  logic [CW-1:0] b_cnt [2];
  logic [63:0]   b_mem [2][DEPTH];
  logic          tag_mem [TD];
  logic [TW-1:0] t_wp, t_rp;
  logic [TCW-1:0] t_cnt;
  logic          t_full, t_push, t_pop, t_head, err_set;

  assign req_v = {i_req1_valid, i_req0_valid};
  assign rsp_r = {i_rsp1_ready, i_rsp0_ready};

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      elig[n]    = i_rst_n & req_v[n] & (credit[n] < CW'(DEPTH));
      rsp_pop[n] = (b_cnt[n] != '0) & rsp_r[n];
      b_full[n]  = (b_cnt[n] == CW'(DEPTH));
    end
  end

  assign grant[0] = elig[0] & (~rr | ~elig[1]);
  assign grant[1] = elig[1] & (rr | ~elig[0]);
  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];

  assign t_full = (t_cnt == TCW'(TD));
  assign t_pop  = i_des_dv & (t_cnt != '0);
  assign t_push = (|grant) & (~t_full | t_pop);
  assign t_head = tag_mem[t_rp];

  assign buf_wr[0] = t_pop & ~t_head & (~b_full[0] | rsp_pop[0]);
  assign buf_wr[1] = t_pop & t_head & (~b_full[1] | rsp_pop[1]);

  // Dropped results, orphan pipeline outputs and tag overruns all latch o_err
  assign err_set = (i_des_dv & (t_cnt == '0))
                 | (t_pop & ~t_head & b_full[0] & ~rsp_pop[0])
                 | (t_pop & t_head & b_full[1] & ~rsp_pop[1])
                 | ((|grant) & t_full & ~t_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr              <= 1'b0;
      o_des_dv        <= 1'b0;
      o_des_cleartext <= '0;
      o_des_key       <= '0;
      o_err           <= 1'b0;
      t_wp            <= '0;
      t_rp            <= '0;
      t_cnt           <= '0;
      for (int n = 0; n < 2; n++) begin
        credit[n] <= '0;
        b_wp[n]   <= '0;
        b_rp[n]   <= '0;
        b_cnt[n]  <= '0;
      end
    end else begin
      o_des_dv <= |grant;
      if (|grant) begin
        rr              <= grant[0];
        o_des_cleartext <= grant[1] ? i_req1_data : i_req0_data;
        o_des_key       <= grant[1] ? i_req1_key : i_req0_key;
      end
      if (err_set) o_err <= 1'b1;
      if (t_push) t_wp <= (t_wp == TW'(TD - 1)) ? '0 : t_wp + TW'(1);
      if (t_pop) t_rp <= (t_rp == TW'(TD - 1)) ? '0 : t_rp + TW'(1);
      if (t_push && !t_pop) t_cnt <= t_cnt + TCW'(1);
      else if (!t_push && t_pop) t_cnt <= t_cnt - TCW'(1);
      for (int n = 0; n < 2; n++) begin
        if (grant[n] && !rsp_pop[n]) credit[n] <= credit[n] + CW'(1);
        else if (!grant[n] && rsp_pop[n]) credit[n] <= credit[n] - CW'(1);
        if (buf_wr[n]) b_wp[n] <= b_wp[n] + AW'(1);
        if (rsp_pop[n]) b_rp[n] <= b_rp[n] + AW'(1);
        if (buf_wr[n] && !rsp_pop[n]) b_cnt[n] <= b_cnt[n] + CW'(1);
        else if (!buf_wr[n] && rsp_pop[n]) b_cnt[n] <= b_cnt[n] - CW'(1);
      end
    end
  end

  // Storage carries no reset; the counters alone define what is valid
  always_ff @(posedge i_clk) begin
    if (t_push) tag_mem[t_wp] <= grant[1];
    for (int n = 0; n < 2; n++)
      if (buf_wr[n]) b_mem[n][b_wp[n]] <= i_des_ciphertext;
  end

  assign o_rsp0_valid = (b_cnt[0] != '0);
  assign o_rsp1_valid = (b_cnt[1] != '0);
  assign o_rsp0_data  = b_mem[0][b_rp[0]];
  assign o_rsp1_data  = b_mem[1][b_rp[1]];
  assign o_busy = (t_cnt != '0) | o_rsp0_valid | o_rsp1_valid | o_des_dv;

endmodule

// File: tb/tb_des_arbiter.sv
// Bench for des_arbiter: behavioural DES pipeline, directed vectors,
// in-order response scoreboard per requester.
module tb_des_arbiter;
  localparam int DEPTH = 4;
  localparam int LAT   = 1;
  localparam logic [63:0] REF_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] REF_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] REF_CT  = 64'h85E813540F0AB405;

  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
    10,2,59,51,43,35,27, 19,11,3,60,52,44,36, 63,55,47,39,31,23,15,
    7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
    23,19,12,4,26,8, 16,7,27,20,13,2, 41,52,31,37,47,55,
    30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int IPT [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int PT [32] = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
    2,8,24,14, 32,27,3,9, 19,13,30,6, 22,11,4,25};
  localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B4192E006ADF358_21E74A8DFC90356B};

  function automatic logic [63:0] des_enc(input logic [63:0] k,
                                          input logic [63:0] d);
    logic [55:0] cd;
    logic [27:0] c, dd;
    logic [47:0] sk [16];
    logic [47:0] e;
    logic [63:0] ip, pre, res;
    logic [31:0] l, r, s, f, tmp;
    logic [255:0] sbv;
    logic [5:0] six;
    int idx;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
    c = cd[55:28];
    dd = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < SHIFTS[n]; j++) begin
        c = {c[26:0], c[27]};
        dd = {dd[26:0], dd[27]};
      end
      cd = {c, dd};
      for (int i = 0; i < 48; i++) sk[n][47-i] = cd[56-PC2[i]];
    end
    for (int i = 0; i < 64; i++) ip[63-i] = d[64-IPT[i]];
    l = ip[63:32];
    r = ip[31:0];
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 48; i++)
        e[47-i] = r[31-((4*(i/6)+(i%6)+31)%32)];
      e = e ^ sk[n];
      for (int b = 0; b < 8; b++) begin
        six = e[47-6*b -: 6];
        idx = 32'({six[5], six[0]}) * 16 + 32'(six[4:1]);
        sbv = SB[b];
        s[31-4*b -: 4] = sbv[255-4*idx -: 4];
      end
      for (int i = 0; i < 32; i++) f[31-i] = s[32-PT[i]];
      tmp = r;
      r = l ^ f;
      l = tmp;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[64-IPT[i]] = pre[63-i];
    return res;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [63:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [63:0] rsp0_data, rsp1_data, des_pt, des_key, des_ct;
  logic des_dv_o, des_dv_i, busy, err;
  logic force_dv = 1'b0;
  logic [63:0] force_ct = '0;

  always #5 clk = ~clk;

  des_arbiter #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .i_req0_data(req0_data),
    .i_req0_key(req0_key), .o_req0_ready(req0_ready),
    .i_req1_valid(req1_valid), .i_req1_data(req1_data),
    .i_req1_key(req1_key), .o_req1_ready(req1_ready),
    .o_rsp0_valid(rsp0_valid), .o_rsp0_data(rsp0_data),
    .i_rsp0_ready(rsp0_ready),
    .o_rsp1_valid(rsp1_valid), .o_rsp1_data(rsp1_data),
    .i_rsp1_ready(rsp1_ready),
    .o_des_cleartext(des_pt), .o_des_key(des_key), .o_des_dv(des_dv_o),
    .i_des_ciphertext(des_ct), .i_des_dv(des_dv_i),
    .o_busy(busy), .o_err(err));

  logic [LAT-1:0] p_dv;
  logic [63:0] p_ct [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_dv <= '0;
      for (int i = 0; i < LAT; i++) p_ct[i] <= '0;
    end else begin
      p_dv[0] <= des_dv_o;
      p_ct[0] <= des_dv_o ? des_enc(des_key, des_pt) : 64'd0;
      for (int i = 1; i < LAT; i++) begin
        p_dv[i] <= p_dv[i-1];
        p_ct[i] <= p_ct[i-1];
      end
    end
  end

  assign des_dv_i = p_dv[LAT-1] | force_dv;
  assign des_ct = force_dv ? force_ct : p_ct[LAT-1];

  int nchk = 0;
  int nerr = 0;
  logic [63:0] exp0 [$];
  logic [63:0] exp1 [$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) exp0.push_back(des_enc(req0_key, req0_data));
      if (req1_valid && req1_ready) exp1.push_back(des_enc(req1_key, req1_data));
      if (rsp0_valid && rsp0_ready) begin
        check("rsp0_pending", 64'(exp0.size() > 0), 64'd1);
        if (exp0.size() > 0) check("rsp0_data", rsp0_data, exp0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        check("rsp1_pending", 64'(exp1.size() > 0), 64'd1);
        if (exp1.size() > 0) check("rsp1_data", rsp1_data, exp1.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    force_dv = 0;
    rst_n = 0;
    exp0.delete();
    exp1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  int lat, acc0, acc1, g;
  logic [63:0] d0, d1;

  initial begin
    // reset state, requester 0 already presenting a block
    #2;
    req0_valid = 1; req0_key = REF_KEY; req0_data = REF_PT;
    rst_n = 0;
    #1;
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_des_dv", 64'(des_dv_o), 64'd0);
    check("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_des_pt", des_pt, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // single reference block
    @(negedge clk);
    check("t1_ready0", 64'(req0_ready), 64'd1);
    cyc();
    req0_valid = 0;
    @(negedge clk);
    check("t1_des_dv", 64'(des_dv_o), 64'd1);
    check("t1_des_pt", des_pt, REF_PT);
    check("t1_des_key", des_key, REF_KEY);
    check("t1_busy", 64'(busy), 64'd1);
    lat = 1;
    while (!rsp0_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", 64'(lat), 64'(LAT + 2));
    check("t1_rsp0_data", rsp0_data, REF_CT);
    check("t1_rsp1_valid", 64'(rsp1_valid), 64'd0);
    cyc();
    rsp0_ready = 1;
    cyc();
    rsp0_ready = 0;
    @(negedge clk);
    check("t1_rsp0_empty", 64'(rsp0_valid), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_rsp1_never", 64'(rsp1_valid), 64'd0);

    // both requesters streaming, grants alternate from 0
    cyc();
    do_reset();
    d0 = 64'h1000_0000_0000_0000;
    d1 = 64'h2000_0000_0000_0000;
    req0_key = 64'h0E329232EA6D0D73; req1_key = REF_KEY;
    req0_data = d0; req1_data = d1;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      g = req0_ready ? 0 : (req1_ready ? 1 : 3);
      check("t2_grant", 64'(g), 64'(i % 2));
      if (i > 0) check("t2_des_dv", 64'(des_dv_o), 64'd1);
      cyc();
      if (g == 0) begin d0++; req0_data = d0; end
      if (g == 1) begin d1++; req1_data = d1; end
    end
    req0_valid = 0; req1_valid = 0;
    repeat (8) cyc();
    check("t2_drain0", 64'(exp0.size()), 64'd0);
    check("t2_drain1", 64'(exp1.size()), 64'd0);
    check("t2_idle", 64'(busy), 64'd0);

    // credit stall on requester 0
    do_reset();
    d0 = 64'h3000_0000_0000_0000;
    req0_data = d0; req0_valid = 1;
    acc0 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      g = 32'(req0_ready);
      acc0 += g;
      cyc();
      if (g == 1) begin d0++; req0_data = d0; end
    end
    check("t3_acc_limit", 64'(acc0), 64'(DEPTH));
    @(negedge clk);
    check("t3_stalled", 64'(req0_ready), 64'd0);
    cyc();
    rsp0_ready = 1;
    acc0 = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      g = 32'(req0_ready);
      acc0 += g;
      cyc();
      rsp0_ready = 0;
      if (g == 1) begin d0++; req0_data = d0; end
    end
    check("t3_one_more", 64'(acc0), 64'd1);

    // requester 1 flows freely past stalled requester 0
    d1 = 64'h4000_0000_0000_0000;
    req1_data = d1; req1_valid = 1; rsp1_ready = 1;
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc0 += 32'(req0_ready);
      g = 32'(req1_ready);
      acc1 += g;
      cyc();
      if (g == 1) begin d1++; req1_data = d1; end
    end
    check("t4_req1_grants", 64'(acc1), 64'd8);
    check("t4_req0_grants", 64'(acc0), 64'd0);
    req0_valid = 0; req1_valid = 0;
    repeat (4) cyc();
    check("t4_drain1", 64'(exp1.size()), 64'd0);

    // spurious pipeline output while idle
    do_reset();
    force_ct = 64'hDEAD_BEEF_0000_0001;
    force_dv = 1;
    cyc();
    force_dv = 0;
    @(negedge clk);
    check("t5_err", 64'(err), 64'd1);
    check("t5_rsp0", 64'(rsp0_valid), 64'd0);
    check("t5_rsp1", 64'(rsp1_valid), 64'd0);
    repeat (4) cyc();
    check("t5_err_sticky", 64'(err), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    rst_n = 0;
    #1;
    check("t5_err_clear", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // reset with three blocks in flight
    d0 = 64'h5000_0000_0000_0000;
    req0_key = REF_KEY; req0_data = d0; req0_valid = 1;
    acc0 = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      g = 32'(req0_ready);
      acc0 += g;
      cyc();
      if (g == 1) begin d0++; req0_data = d0; end
    end
    check("t6_acc", 64'(acc0), 64'd3);
    check("t6_busy_pre", 64'(busy), 64'd1);
    rst_n = 0;
    #1;
    check("t6_des_dv", 64'(des_dv_o), 64'd0);
    check("t6_rsp0", 64'(rsp0_valid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_des_key", des_key, 64'd0);
    check("t6_ready0", 64'(req0_ready), 64'd0);
    req0_valid = 0;
    exp0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (5) cyc();
    check("t6_stale0", 64'(rsp0_valid), 64'd0);
    check("t6_stale1", 64'(rsp1_valid), 64'd0);
    req0_data = REF_PT; req0_valid = 1;
    @(negedge clk);
    check("t6_new_ready", 64'(req0_ready), 64'd1);
    cyc();
    req0_valid = 0;
    lat = 0;
    while (!rsp0_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t6_new_valid", 64'(rsp0_valid), 64'd1);
    check("t6_new_data", rsp0_data, REF_CT);
    cyc();
    rsp0_ready = 1;
    cyc();
    rsp0_ready = 0;
    repeat (2) cyc();
    check("t6_done", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
